// File: rtl/cvxif_simd_maqa_unit.sv
// CV-X-IF SIMD multiply-accumulate-quad unit: rd = rs3 + sum(rs1.lane * rs2.lane).
// Commit-ordered instruction buffer feeding a product stage and a sum/saturate result stage.
module cvxif_simd_maqa_unit #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned LANE_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ID_W   = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            issue_valid_i,
    output logic            issue_ready_o,
    input  logic [ID_W-1:0] issue_id_i,
    input  logic [4:0]      issue_rd_i,
    input  logic [1:0]      issue_mode_i,
    input  logic [XLEN-1:0] issue_rs1_i,
    input  logic [XLEN-1:0] issue_rs2_i,
    input  logic [XLEN-1:0] issue_rs3_i,
    input  logic            commit_valid_i,
    input  logic [ID_W-1:0] commit_id_i,
    input  logic            commit_kill_i,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic [ID_W-1:0] result_id_o,
    output logic [4:0]      result_rd_o,
    output logic            result_we_o,
    output logic [XLEN-1:0] result_data_o,
    output logic            commit_err_o
);

    localparam int unsigned NLANE = XLEN / LANE_W;
    localparam int unsigned PW    = 2 * LANE_W + 2;
    localparam int unsigned SW    = XLEN + PW;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam logic signed [SW-1:0] SMAX = {{(PW + 1){1'b0}}, {(XLEN - 1){1'b1}}};
    localparam logic signed [SW-1:0] SMIN = {{(PW + 1){1'b1}}, {(XLEN - 1){1'b0}}};

    if (LANE_W != 8 && LANE_W != 16) begin : g_bad_lane
        $error("cvxif_simd_maqa_unit: LANE_W must be 8 or 16");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cvxif_simd_maqa_unit: DEPTH must be a power of 2 and at least 2");
    end

    logic [ID_W-1:0] buf_id   [DEPTH];
    logic [4:0]      buf_rd   [DEPTH];
    logic [1:0]      buf_mode [DEPTH];
    logic [XLEN-1:0] buf_rs1  [DEPTH];
    logic [XLEN-1:0] buf_rs2  [DEPTH];
    logic [XLEN-1:0] buf_rs3  [DEPTH];
    logic [DEPTH-1:0] buf_kill;

    logic [AW-1:0] head, tail, cptr;
    logic [AW:0]   count, nres;
    logic          err;

    logic full, pending, push, pop, cm_hit, head_res, head_kill, s1_load;
    logic s1_valid, s1_ready, s1_adv, s2_ready;

    logic [NLANE-1:0][PW-1:0] s1_prod;
    logic [XLEN-1:0]          s1_rs3;
    logic [1:0]               s1_mode;
    logic [ID_W-1:0]          s1_id;
    logic [4:0]               s1_rd;

    logic            res_valid;
    logic [ID_W-1:0] res_id;
    logic [4:0]      res_rd;
    logic [XLEN-1:0] res_data;

    // Entries head..cptr-1 are resolved (committed or killed); buf_kill tells which.
    // A commit hitting an unresolved head resolves it in the same cycle it dispatches.
    assign full      = (count == (AW + 1)'(DEPTH));
    assign pending   = (nres < count);
    assign push      = issue_valid_i && !full;
    assign cm_hit    = commit_valid_i && pending && (buf_id[cptr] == commit_id_i);
    assign head_res  = (nres != '0) || cm_hit;
    assign head_kill = (nres != '0) ? buf_kill[head] : commit_kill_i;
    assign s2_ready  = !res_valid || result_ready_i;
    assign s1_ready  = !s1_valid || s2_ready;
    assign s1_adv    = s1_valid && s2_ready;
    assign pop       = head_res && (head_kill || s1_ready);
    assign s1_load   = pop && !head_kill;

    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_id[tail]   <= issue_id_i;
            buf_rd[tail]   <= issue_rd_i;
            buf_mode[tail] <= issue_mode_i;
            buf_rs1[tail]  <= issue_rs1_i;
            buf_rs2[tail]  <= issue_rs2_i;
            buf_rs3[tail]  <= issue_rs3_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head     <= '0;
            tail     <= '0;
            cptr     <= '0;
            count    <= '0;
            nres     <= '0;
            buf_kill <= '0;
            err      <= 1'b0;
        end else begin
            if (push) begin
                tail           <= tail + 1'b1;
                buf_kill[tail] <= 1'b0;
            end
            if (pop) head <= head + 1'b1;
            if (cm_hit) begin
                cptr           <= cptr + 1'b1;
                buf_kill[cptr] <= commit_kill_i;
            end
            if (commit_valid_i && !cm_hit) err <= 1'b1;
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
            nres  <= nres + (AW + 1)'(cm_hit) - (AW + 1)'(pop);
        end
    end

    logic [NLANE-1:0][PW-1:0] prod;
    logic [LANE_W-1:0]        la, lb;
    logic signed [PW-1:0]     xa, xb;
    logic                     sa, sb;

    always_comb begin
        prod = '0;
        la   = '0;
        lb   = '0;
        xa   = '0;
        xb   = '0;
        sa   = (buf_mode[head] != 2'b01);
        sb   = (buf_mode[head] == 2'b00) || (buf_mode[head] == 2'b11);
        for (int unsigned l = 0; l < NLANE; l++) begin
            la      = buf_rs1[head][l * LANE_W +: LANE_W];
            lb      = buf_rs2[head][l * LANE_W +: LANE_W];
            xa      = {{(PW - LANE_W){sa & la[LANE_W-1]}}, la};
            xb      = {{(PW - LANE_W){sb & lb[LANE_W-1]}}, lb};
            prod[l] = xa * xb;
        end
    end

    always_ff @(posedge clk_i) begin
        if (s1_load) begin
            s1_prod <= prod;
            s1_rs3  <= buf_rs3[head];
            s1_mode <= buf_mode[head];
            s1_id   <= buf_id[head];
            s1_rd   <= buf_rd[head];
        end
    end

    logic signed [SW-1:0] sum;
    logic [XLEN-1:0]      sum_out;

    always_comb begin
        sum = {{PW{s1_rs3[XLEN-1]}}, s1_rs3};
        for (int unsigned l = 0; l < NLANE; l++) begin
            sum = sum + {{(SW - PW){s1_prod[l][PW-1]}}, s1_prod[l]};
        end
        sum_out = sum[XLEN-1:0];
        if (s1_mode == 2'b11) begin
            if (sum > SMAX)      sum_out = SMAX[XLEN-1:0];
            else if (sum < SMIN) sum_out = SMIN[XLEN-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid  <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_rd    <= '0;
            res_data  <= '0;
        end else begin
            if (s1_load)     s1_valid <= 1'b1;
            else if (s1_adv) s1_valid <= 1'b0;
            if (s1_adv) begin
                res_valid <= 1'b1;
                res_id    <= s1_id;
                res_rd    <= s1_rd;
                res_data  <= sum_out;
            end else if (result_ready_i) begin
                res_valid <= 1'b0;
            end
        end
    end

    assign issue_ready_o  = !full;
    assign result_valid_o = res_valid;
    assign result_id_o    = res_id;
    assign result_rd_o    = res_rd;
    assign result_data_o  = res_data;
    assign result_we_o    = res_valid && (res_rd != 5'd0);
    assign commit_err_o   = err;

endmodule

// File: tb/tb_cvxif_simd_maqa_unit.sv
// Bench for cvxif_simd_maqa_unit: directed vectors plus random traffic against an arithmetic model.
// Two instances (8-bit and 16-bit lanes) share all stimulus.
module tb_cvxif_simd_maqa_unit;

    typedef struct {
        logic [2:0]  id;
        logic [4:0]  rd;
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, commit_valid, commit_kill, result_ready;
    logic [2:0]  issue_id, commit_id;
    logic [4:0]  issue_rd;
    logic [1:0]  issue_mode;
    logic [31:0] issue_rs1, issue_rs2, issue_rs3;

    logic        issue_ready, result_valid, result_we, commit_err;
    logic [2:0]  result_id;
    logic [4:0]  result_rd;
    logic [31:0] result_data;
    logic        r16_issue_ready, r16_valid, r16_we, r16_err;
    logic [2:0]  r16_id;
    logic [4:0]  r16_rd;
    logic [31:0] r16_data;

    always #5 clk = ~clk;

    cvxif_simd_maqa_unit #(.XLEN(32), .LANE_W(8), .DEPTH(4), .ID_W(3)) u_dut8 (
        .clk_i(clk), .rst_ni(rst_n),
        .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_id_i(issue_id),
        .issue_rd_i(issue_rd), .issue_mode_i(issue_mode),
        .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2), .issue_rs3_i(issue_rs3),
        .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
        .result_valid_o(result_valid), .result_ready_i(result_ready), .result_id_o(result_id),
        .result_rd_o(result_rd), .result_we_o(result_we), .result_data_o(result_data),
        .commit_err_o(commit_err)
    );

    cvxif_simd_maqa_unit #(.XLEN(32), .LANE_W(16), .DEPTH(4), .ID_W(3)) u_dut16 (
        .clk_i(clk), .rst_ni(rst_n),
        .issue_valid_i(issue_valid), .issue_ready_o(r16_issue_ready), .issue_id_i(issue_id),
        .issue_rd_i(issue_rd), .issue_mode_i(issue_mode),
        .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2), .issue_rs3_i(issue_rs3),
        .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
        .result_valid_o(r16_valid), .result_ready_i(result_ready), .result_id_o(r16_id),
        .result_rd_o(r16_rd), .result_we_o(r16_we), .result_data_o(r16_data),
        .commit_err_o(r16_err)
    );

    int unsigned n_checks  = 0;
    int unsigned n_errors  = 0;
    int unsigned n_results = 0;
    entry_t      pend[$];
    entry_t      exp_q[$];
    entry_t      nul;
    logic [2:0]  next_id = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    // Lane-wise integer arithmetic straight from the instruction definition.
    function automatic logic [31:0] ref_maqa(input int unsigned lw, input logic [1:0] mode,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c);
        longint      acc, x, y;
        logic [31:0] ua, ub;
        acc = longint'($signed(c));
        for (int unsigned i = 0; i < 32 / lw; i++) begin
            ua = (a >> (i * lw)) & ((32'h1 << lw) - 32'h1);
            ub = (b >> (i * lw)) & ((32'h1 << lw) - 32'h1);
            x  = longint'(ua);
            y  = longint'(ub);
            if (mode != 2'b01 && ua[lw-1]) x = x - (longint'(1) << lw);
            if ((mode == 2'b00 || mode == 2'b11) && ub[lw-1]) y = y - (longint'(1) << lw);
            acc = acc + x * y;
        end
        if (mode == 2'b11) begin
            if (acc > 64'sd2147483647)       acc = 64'sd2147483647;
            else if (acc < -64'sd2147483648) acc = -64'sd2147483648;
        end
        return acc[31:0];
    endfunction

    logic        held_v = 1'b0;
    logic [2:0]  held_id;
    logic [4:0]  held_rd;
    logic [31:0] held_data;

    always @(negedge clk) begin
        entry_t e;
        if (result_valid) begin
            if (held_v) begin
                chk("hold_id", result_id, held_id);
                chk("hold_rd", result_rd, held_rd);
                chk("hold_data", result_data, held_data);
            end
            if (result_ready) begin
                held_v = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("spurious_result", result_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    n_results++;
                    chk("res_id", result_id, e.id);
                    chk("res_rd", result_rd, e.rd);
                    chk("res_we", result_we, e.rd != 5'd0);
                    chk("res_data8", result_data, ref_maqa(8, e.mode, e.a, e.b, e.c));
                    chk("res_valid16", r16_valid, 1);
                    chk("res_id16", r16_id, e.id);
                    chk("res_we16", r16_we, r16_rd != 5'd0);
                    chk("res_data16", r16_data, ref_maqa(16, e.mode, e.a, e.b, e.c));
                end
            end else begin
                held_v    = 1'b1;
                held_id   = result_id;
                held_rd   = result_rd;
                held_data = result_data;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    // One clock of stimulus, entered and left 1 time unit after a rising edge.
    task automatic step(input bit iss, input entry_t ni, input bit cm, input bit kill);
        entry_t e;
        issue_valid  = 1'b0;
        commit_valid = 1'b0;
        commit_kill  = 1'b0;
        if (cm && pend.size() > 0) begin
            e            = pend.pop_front();
            commit_valid = 1'b1;
            commit_id    = e.id;
            commit_kill  = kill;
            if (!kill) exp_q.push_back(e);
        end
        if (iss && issue_ready) begin
            e           = ni;
            e.id        = next_id;
            next_id     = next_id + 3'd1;
            issue_valid = 1'b1;
            issue_id    = e.id;
            issue_rd    = e.rd;
            issue_mode  = e.mode;
            issue_rs1   = e.a;
            issue_rs2   = e.b;
            issue_rs3   = e.c;
            pend.push_back(e);
        end
        @(posedge clk);
        #1;
        issue_valid  = 1'b0;
        commit_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned t = 0;
        result_ready = 1'b1;
        while (pend.size() > 0) step(0, nul, 1, 0);
        while (exp_q.size() != 0 && t < 100) begin
            step(0, nul, 0, 0);
            t++;
        end
        chk("drain_left", exp_q.size(), 0);
        step(0, nul, 0, 0);
    endtask

    task automatic run_vec(input string tag, input logic [1:0] mode, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] c,
                           input logic [31:0] want, input bit lane16);
        entry_t e;
        e = '{id: 3'd0, rd: 5'd5, mode: mode, a: a, b: b, c: c};
        result_ready = 1'b1;
        step(1, e, 0, 0);
        step(0, nul, 1, 0);
        chk({tag, "_lat1"}, result_valid, 0);
        step(0, nul, 0, 0);
        chk({tag, "_lat2"}, result_valid, 1);
        chk(tag, lane16 ? r16_data : result_data, want);
        chk({tag, "_we"}, result_we, 1);
        drain();
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 4))
            0:       return 32'h7F7F7F7F;
            1:       return 32'h80808080;
            2:       return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        entry_t      e;
        int unsigned base;
        nul          = '{id: 3'd0, rd: 5'd0, mode: 2'd0, a: 32'd0, b: 32'd0, c: 32'd0};
        rst_n        = 1'b0;
        issue_valid  = 1'b0;
        commit_valid = 1'b0;
        commit_kill  = 1'b0;
        result_ready = 1'b1;
        issue_id     = '0;
        commit_id    = '0;
        issue_rd     = '0;
        issue_mode   = '0;
        issue_rs1    = '0;
        issue_rs2    = '0;
        issue_rs3    = '0;
        #2;
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_valid", result_valid, 0);
        chk("rst_we", result_we, 0);
        chk("rst_data", result_data, 0);
        chk("rst_id", result_id, 0);
        chk("rst_rd", result_rd, 0);
        chk("rst_err", commit_err, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_vec("v_s8", 2'b00, 32'hFF020304, 32'h01010101, 32'd10, 32'h00000012, 0);
        run_vec("v_u8", 2'b01, 32'hFF020304, 32'h01010101, 32'd10, 32'h00000112, 0);
        run_vec("v_su8", 2'b10, 32'hFF020304, 32'hFF010101, 32'd10, 32'hFFFFFF14, 0);
        run_vec("v_sat", 2'b11, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h7FFFFF00, 32'h7FFFFFFF, 0);
        run_vec("v_wrap", 2'b00, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h7FFFFF00, 32'h8000FB04, 0);
        run_vec("v_s16", 2'b00, 32'hFFFF0002, 32'h00030004, 32'd0, 32'h00000005, 1);

        // Fill, kill id1, stall the result port, then drain in order.
        base         = n_results;
        next_id      = '0;
        result_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e = '{id: 3'd0, rd: 5'(i + 1), mode: 2'(i), a: rnd_op(), b: rnd_op(), c: $urandom};
            step(1, e, 0, 0);
        end
        chk("full_ready", issue_ready, 0);
        chk("full_ready16", r16_issue_ready, 0);
        step(0, nul, 1, 0);
        chk("ready_after_pop", issue_ready, 1);
        step(0, nul, 1, 1);
        step(0, nul, 1, 0);
        step(0, nul, 1, 0);
        repeat (3) step(0, nul, 0, 0);
        chk("stall_valid", result_valid, 1);
        chk("stall_id", result_id, 0);
        drain();
        chk("fill_count", n_results - base, 3);

        for (int c = 0; c < 600; c++) begin
            result_ready = ($urandom_range(0, 9) < 7);
            e = '{id: 3'd0, rd: 5'($urandom_range(0, 31)), mode: 2'($urandom_range(0, 3)),
                  a: rnd_op(), b: rnd_op(), c: rnd_op()};
            step($urandom_range(0, 1) == 1, e, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
        end
        drain();
        chk("err_clear", commit_err, 0);

        // Mismatched commit id: ignored, error sticks, real commit still works.
        base = n_results;
        e    = '{id: 3'd0, rd: 5'd9, mode: 2'b00, a: 32'h01020304, b: 32'h01010101, c: 32'd1};
        step(1, e, 0, 0);
        commit_valid = 1'b1;
        commit_id    = pend[0].id + 3'd1;
        commit_kill  = 1'b0;
        @(posedge clk);
        #1;
        commit_valid = 1'b0;
        chk("err_set", commit_err, 1);
        chk("err_set16", r16_err, 1);
        repeat (3) step(0, nul, 0, 0);
        chk("err_no_result", result_valid, 0);
        drain();
        chk("err_sticky", commit_err, 1);
        chk("err_result_count", n_results - base, 1);

        // Reset with work in both pipeline stages.
        result_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            e = '{id: 3'd0, rd: 5'd3, mode: 2'b01, a: $urandom, b: $urandom, c: $urandom};
            step(1, e, 0, 0);
        end
        step(0, nul, 1, 0);
        step(0, nul, 1, 0);
        chk("pre_reset_valid", result_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", result_valid, 0);
        chk("mid_rst_ready", issue_ready, 1);
        chk("mid_rst_err", commit_err, 0);
        chk("mid_rst_data", result_data, 0);
        chk("mid_rst_we", result_we, 0);
        pend.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        result_ready = 1'b1;
        repeat (6) step(0, nul, 0, 0);
        chk("post_rst_idle", result_valid, 0);
        chk("post_rst_ready", issue_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
